// File: rtl/mdr_sequencer.sv
// rtl/mdr_sequencer.sv - control FSM for the multiply/divide/root (MDR) system
//
// Sequences one operation: operand capture (X, then Y unless ROOT), operand
// verification, engine select/init, calculation and completion reporting.
// Optional feature macro: MDR_SEQ_WATCHDOG_EN (abort CALCULATION after TIMEOUT cycles).
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   start, load         one-cycle pulses from the user front end
//   op_sel              operation: 0 MULT, 1 DIV, 2 ROOT, 3 NON
//   data_in             two's complement operand input
//   eng_done, eng_ovf   completion and overflow from the selected engine
//   clean, init         one-cycle datapath clear and engine init pulses
//   load_x, load_y      waiting for X / Y operand
//   data_x, data_y      registered operands
//   eng_en              one-hot engine enable (bit0 mult, bit1 div, bit2 root)
//   busy, ready, error  status; error is meaningful in READY
//   state               current state encoding
//   cycles              CALCULATION cycles of the last operation
`timescale 1ns/1ps

module mdr_sequencer #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 40,
    parameter int CW      = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          load,
    input  logic [1:0]    op_sel,
    input  logic [DW-1:0] data_in,
    input  logic          eng_done,
    input  logic          eng_ovf,
    output logic          clean,
    output logic          load_x,
    output logic          load_y,
    output logic [DW-1:0] data_x,
    output logic [DW-1:0] data_y,
    output logic [2:0]    eng_en,
    output logic          init,
    output logic          busy,
    output logic          ready,
    output logic          error,
    output logic [3:0]    state,
    output logic [CW-1:0] cycles
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_CLEAN  = 4'd1,
        S_WAIT_X = 4'd2,
        S_WAIT_Y = 4'd3,
        S_SAVE_X = 4'd4,
        S_SAVE_Y = 4'd5,
        S_VERIFY = 4'd6,
        S_INIT   = 4'd7,
        S_CALC   = 4'd8,
        S_READY  = 4'd9
    } state_t;

    localparam logic [1:0]    OP_DIV  = 2'd1;
    localparam logic [1:0]    OP_ROOT = 2'd2;
    localparam logic [1:0]    OP_NON  = 2'd3;
    localparam logic [CW-1:0] CNT_MAX = '1;

    if (TIMEOUT >= (1 << CW)) begin : g_cw_too_narrow
        $error("mdr_sequencer: CW too narrow to count TIMEOUT cycles");
    end

    state_t        st_q, st_d;
    logic [1:0]    op_q;
    logic [CW-1:0] cnt_q;
    logic          verify_fail;
    logic          timeout;

    // Operands that no engine can process are rejected before any engine starts.
    assign verify_fail = (op_q == OP_NON)
                      || ((op_q == OP_DIV) && (data_y == '0))
                      || ((op_q == OP_ROOT) && data_x[DW-1]);

`ifdef MDR_SEQ_WATCHDOG_EN
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    logic wd_clean_q;

    // cnt_q holds the number of CALCULATION cycles already completed, so the
    // TIMEOUT-th cycle is the one where it equals TIMEOUT-1.
    assign timeout = (st_q == S_CALC) && !eng_done && (cnt_q == WD_LAST);

    // The abort pulse to the engine lands in the first READY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wd_clean_q <= 1'b0;
        else      wd_clean_q <= timeout;
    end

    assign clean = (st_q == S_CLEAN) || wd_clean_q;
`else
    assign timeout = 1'b0;
    assign clean   = (st_q == S_CLEAN);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) st_q <= S_IDLE;
        else      st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            S_IDLE:   if (start) st_d = S_CLEAN;
            S_CLEAN:  st_d = S_WAIT_X;
            S_WAIT_X: if (load) st_d = S_SAVE_X;
            S_SAVE_X: st_d = (op_q == OP_ROOT) ? S_VERIFY : S_WAIT_Y;
            S_WAIT_Y: if (load) st_d = S_SAVE_Y;
            S_SAVE_Y: st_d = S_VERIFY;
            S_VERIFY: st_d = verify_fail ? S_READY : S_INIT;
            S_INIT:   st_d = S_CALC;
            S_CALC:   if (eng_done || timeout) st_d = S_READY;
            S_READY:  if (start) st_d = S_CLEAN;
            default:  st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= '0;
            data_x <= '0;
            data_y <= '0;
            error  <= 1'b0;
            cycles <= '0;
            cnt_q  <= '0;
            eng_en <= '0;
        end else begin
            case (st_q)
                S_IDLE, S_READY: begin
                    if (start) op_q <= op_sel;
                end
                S_CLEAN: begin
                    data_x <= '0;
                    data_y <= '0;
                    error  <= 1'b0;
                    cycles <= '0;
                end
                S_SAVE_X: data_x <= data_in;
                S_SAVE_Y: data_y <= data_in;
                S_VERIFY: begin
                    // Enable is raised here so the engine sees it with init.
                    if (verify_fail) error  <= 1'b1;
                    else             eng_en <= 3'b001 << op_q;
                end
                S_INIT: cnt_q <= '0;
                S_CALC: begin
                    if (eng_done) begin
                        cycles <= (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
                        error  <= eng_ovf;
                        eng_en <= '0;
                    end else if (timeout) begin
                        cycles <= CW'(TIMEOUT);
                        error  <= 1'b1;
                        eng_en <= '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign load_x = (st_q == S_WAIT_X);
    assign load_y = (st_q == S_WAIT_Y);
    assign init   = (st_q == S_INIT);
    assign ready  = (st_q == S_READY);
    assign busy   = (st_q != S_IDLE) && (st_q != S_READY);
    assign state  = st_q;

endmodule

// File: doc/mdr_sequencer.md
Name: mdr_sequencer

Overview:
- Control FSM for the multiply/divide/root (MDR) system.
- Runs the full operation sequence: operand capture (X, then Y), operand verification, engine select and init, and completion/error reporting.
- Drives one of the mult/div/root engines at a time; those engines share the single ALU.
- Sits between the user-input front end (debounced/edge-detected start and load pulses) and the MDR datapath.

Parameters:
- DW, 16, operand width.
- TIMEOUT, 40, max CALCULATION cycles before the watchdog trips (used only with the optional feature).
- CW, 6, width of the calculation cycle counter; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, active-low, asynchronous.
- start  in  1  one-cycle pulse; begins an operation.
- load  in  1  one-cycle pulse; operand on data_in is valid.
- op_sel  in  2  operation: 0 MULT, 1 DIV, 2 ROOT, 3 NON.
- data_in  in  DW  operand input, two's complement.
- eng_done  in  1  selected engine has finished.
- eng_ovf  in  1  engine overflow flag, sampled with eng_done.
- clean  out  1  one-cycle clear pulse to the datapath.
- load_x  out  1  high while waiting for X.
- load_y  out  1  high while waiting for Y.
- data_x  out  DW  registered X operand.
- data_y  out  DW  registered Y operand.
- eng_en  out  3  one-hot engine enable: bit0 mult, bit1 div, bit2 root.
- init  out  1  one-cycle engine init pulse.
- busy  out  1  high in every state except IDLE and READY.
- ready  out  1  high in READY.
- error  out  1  error flag, valid in READY.
- state  out  4  current state encoding, for debug/LEDs.
- cycles  out  CW  number of CALCULATION cycles of the last operation.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE.
  - All outputs 0, including data_x, data_y, cycles and latched op.
  - Reset during any state, including CALCULATION, aborts immediately with no result.
- State encoding: IDLE=0, CLEAN=1, WAIT_X=2, WAIT_Y=3, SAVE_X=4, SAVE_Y=5, VERIFICATION=6, INIT=7, CALCULATION=8, READY=9.
- IDLE: on start, latch op_sel into op_q and go to CLEAN.
- CLEAN (1 cycle): clean=1; clear data_x, data_y, error and cycles; go to WAIT_X.
- WAIT_X: load_x=1; on load go to SAVE_X.
- SAVE_X (1 cycle): data_x <= data_in.
  - If op_q==ROOT, go to VERIFICATION (Y is not requested).
  - Otherwise go to WAIT_Y.
- WAIT_Y: load_y=1; on load go to SAVE_Y.
- SAVE_Y (1 cycle): data_y <= data_in; go to VERIFICATION.
- data_in must be held stable from the load pulse through the SAVE cycle.
- VERIFICATION (1 cycle): error is set, and the next state is READY, on any of:
  - op_q==NON;
  - op_q==DIV and data_y==0;
  - op_q==ROOT and data_x[DW-1]==1.
  - Otherwise go to INIT.
- INIT (1 cycle):
  - init=1.
  - eng_en = one-hot(op_q), held through CALCULATION.
  - cycle counter cleared.
  - Go to CALCULATION.
- CALCULATION:
  - Counter increments each cycle and saturates at 2^CW-1.
  - On eng_done: cycles <= counter+1; error <= eng_ovf; eng_en <= 0; go to READY.
- READY:
  - ready=1; data_x, data_y, error and cycles are held.
  - start: latch op_sel and go to CLEAN.
  - load is ignored.
- Pulse rules:
  - start is ignored in every state except IDLE and READY.
  - load is ignored except in WAIT_X and WAIT_Y.
  - start and load in the same cycle in WAIT_X/WAIT_Y: load is taken.
  - eng_done outside CALCULATION is ignored.
- Output timing: all outputs are registered or decoded from the registered state; no combinational path from an input to an output.
- Minimum latency start→ready, with back-to-back loads and done in the first CALCULATION cycle:
  - MULT/DIV: 9 cycles plus load wait time.
  - ROOT: 7 cycles plus load wait time.

Optional Feature:
- Macro: MDR_SEQ_WATCHDOG_EN.
- Defined: if CALCULATION reaches TIMEOUT cycles without eng_done, then:
  - error=1, cycles=TIMEOUT, eng_en=0;
  - a 1-cycle clean pulse is issued to abort the engine;
  - go to READY.
- Undefined: CALCULATION waits indefinitely for eng_done, and TIMEOUT is unused.

Test Plan:
- MULT happy path: start with op_sel=0, load X=3, load Y=-4, eng_done after 17 cycles with eng_ovf=0 → ready=1, error=0, cycles=17, eng_en was 3'b001 throughout CALCULATION, init pulsed exactly once.
- DIV by zero: op_sel=1, X=100, Y=0 → VERIFICATION goes straight to READY with error=1; init is never asserted and eng_en stays 0.
- ROOT skips Y:
  - op_sel=2, X=144 → after SAVE_X, load_y is never asserted; eng_en=3'b100; on eng_done, ready=1 and error=0.
  - Repeat with X=16'h8000 → error=1 and no init.
- Ignored pulses: start pulse during WAIT_Y and during CALCULATION → no state change; start and load together in WAIT_X → SAVE_X, with data_x taken from data_in.
- Reset mid-op: drop rst during CALCULATION → same-cycle async clear: state=0, eng_en=0, busy=0, data_x=0; after release, IDLE.
- Watchdog (macro defined): MULT with eng_done never asserted → after 40 CALCULATION cycles, error=1, cycles=40, clean pulse, READY. With the macro undefined, the FSM is still in CALCULATION at cycle 100.
